// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo_basic / fifo_reader family.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned RD_BUF_DEPTH = 2;

    // Encoding equals buffer occupancy so the state doubles as the count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered output buffer: head is presented, tail backs it up.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              valid,
    output logic [1:0]        count
);

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    state_d = BUF_ONE;
                    head_d  = push_data;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_d = BUF_FULL;
                        tail_d  = push_data;
                    end
                    2'b01:   state_d = BUF_EMPTY;
                    2'b11:   head_d  = push_data;
                    default: state_d = BUF_ONE;
                endcase
            end
            BUF_FULL: begin
                // Push without pop cannot occur: the reader never overcommits room.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign head_data = head_q;
    assign valid     = (state_q != BUF_EMPTY);
    assign count     = state_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for fifo_basic; hides its one-cycle read latency behind a 2-entry buffer.
// Optional transfer counter rd_count is built when FIFO_READER_COUNT_EN is defined.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [CNT_W-1:0]  rd_count
`endif
);

    logic       inflight_q, inflight_d;
    logic       pop;
    logic [1:0] buf_count;
    logic [2:0] occ_after;

    assign pop = m_valid & m_ready;

    // Room check counts the byte already in flight and credits this cycle's pop.
    always_comb begin
        occ_after  = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
        fifo_rd_en = !rst & enable & !fifo_empty & (occ_after < 3'(RD_BUF_DEPTH));
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_data),
        .valid     (m_valid),
        .count     (buf_count)
    );

    assign busy = m_valid | inflight_q;

`ifdef FIFO_READER_COUNT_EN
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q + CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule
